// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    localparam int DATA_W     = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // funct3 codes 011/110/111 have no load/store meaning here
    function automatic logic size_legal(input logic [2:0] sz);
        case (mem_size_e'(sz))
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_legal = 1'b1;
            default:                        size_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request/response bus between the core (master) and the data memory (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: store byte enables/replicated data and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]                  size,
    input  logic [1:0]                  addr_lo,
    input  logic [DATA_W-1:0]           st_data,
    input  logic [DATA_W-1:0]           ld_word,
    output logic [BYTE_LANES-1:0]       byte_en,
    output logic [BYTE_LANES-1:0][7:0]  st_lanes,
    output logic [DATA_W-1:0]           ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data is replicated across lanes so the enables alone pick the target bytes
    always_comb begin
        byte_en  = '0;
        st_lanes = {BYTE_LANES{st_data[7:0]}};
        case (size[1:0])
            2'b00: byte_en[addr_lo] = 1'b1;
            2'b01: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                st_lanes = st_data;
            end
            default: byte_en = '0;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (mem_size_e'(size))
            SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            SZ_BU:   ld_data = {24'h0, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            SZ_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data memory behind a valid/ready load/store port.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (fault misaligned half/word accesses).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e state, state_nx;
    logic [3:0]  wait_cnt;
    dmem_req_t   req_q;

    logic [BYTE_LANES-1:0][7:0] mem [DEPTH_WORDS];

    logic              rsp_valid_q, rsp_error_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              accept, access, do_write;
    logic [DATA_W-1:0] off, word_off, ld_word, ld_data;
    logic [IDX_W-1:0]  idx;
    logic              addr_err, align_err, err;
    logic [BYTE_LANES-1:0]      byte_en;
    logic [BYTE_LANES-1:0][7:0] st_lanes;

    // Ready is masked by reset so nothing can be accepted while held in reset
    assign bus.req_ready = (state == IDLE) && reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    assign off      = req_q.addr - BASE_ADDR;
    assign word_off = off >> 2;
    assign idx      = word_off[IDX_W-1:0];
    assign addr_err = (req_q.addr < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        case (req_q.size[1:0])
            2'b01:   align_err = req_q.addr[0];
            2'b10:   align_err = |req_q.addr[1:0];
            default: align_err = 1'b0;
        endcase
    end
`else
    assign align_err = 1'b0;
`endif

    assign err      = addr_err || align_err || !size_legal(req_q.size);
    assign do_write = access && !err && req_q.write;
    assign ld_word  = mem[idx];

    dmem_lane_align u_align (
        .size     (req_q.size),
        .addr_lo  (req_q.addr[1:0]),
        .st_data  (req_q.wdata),
        .ld_word  (ld_word),
        .byte_en  (byte_en),
        .st_lanes (st_lanes),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < BYTE_LANES; i++)
                if (byte_en[i]) mem[idx][i] <= st_lanes[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        access   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nx = (WAIT_STATES == 0) ? ACCESS : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nx = ACCESS;
            ACCESS: begin
                access   = 1'b1;
                state_nx = RESP;
            end
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q    <= '{write: bus.req_write, addr: bus.req_addr,
                              size: bus.req_size, wdata: bus.req_wdata};
                wait_cnt <= CNT_INIT;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_error_q <= err;
                rsp_rdata_q <= (err || req_q.write) ? '0 : ld_data;
            end else if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store vectors, byte-level reference model, per-cycle compare.
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1));

    logic        sel = 1'b0, rq_valid = 1'b0, rq_write = 1'b0, rs_ready = 1'b0;
    logic [31:0] rq_addr = '0, rq_wdata = '0;
    logic [2:0]  rq_size = '0;

    assign bus0.req_valid = rq_valid && !sel;
    assign bus1.req_valid = rq_valid && sel;
    assign bus0.rsp_ready = rs_ready && !sel;
    assign bus1.rsp_ready = rs_ready && sel;
    assign bus0.req_write = rq_write;  assign bus1.req_write = rq_write;
    assign bus0.req_addr  = rq_addr;   assign bus1.req_addr  = rq_addr;
    assign bus0.req_size  = rq_size;   assign bus1.req_size  = rq_size;
    assign bus0.req_wdata = rq_wdata;  assign bus1.req_wdata = rq_wdata;

    wire        ready_m  = sel ? bus1.req_ready : bus0.req_ready;
    wire        rvalid_m = sel ? bus1.rsp_valid : bus0.rsp_valid;
    wire [31:0] rdata_m  = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    wire        rerr_m   = sel ? bus1.rsp_error : bus0.rsp_error;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          sel;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          acc;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    logic [31:0] mw [int];

    function automatic int key(input txn_t t);
        return (t.sel ? DEPTH : 0) + int'(t.addr >> 2);
    endfunction

    function automatic int lat(input txn_t t);
        return t.sel ? 4 : 2;
    endfunction

    function automatic bit m_err(input txn_t t);
        if (t.size == 3'b011 || t.size == 3'b110 || t.size == 3'b111) return 1'b1;
        if ((t.addr / 4) >= 32'(DEPTH)) return 1'b1;
        if (MIS && (t.size == 3'b001 || t.size == 3'b101) && (t.addr % 2) != 0) return 1'b1;
        if (MIS && t.size == 3'b010 && (t.addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input txn_t t);
        logic [31:0] w;
        logic [7:0]  by;
        logic [15:0] hw;
        w  = mw.exists(key(t)) ? mw[key(t)] : 32'hx;
        by = 8'(w >> (8 * (t.addr % 4)));
        hw = 16'(w >> (16 * ((t.addr / 2) % 2)));
        case (t.size)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'h0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'h0, hw};
            default: return w;
        endcase
    endfunction

    function automatic void m_store(input txn_t t);
        logic [31:0] w;
        int n, st;
        n  = (t.size == 3'b000) ? 1 : (t.size == 3'b001) ? 2 : 4;
        st = (n == 1) ? int'(t.addr % 4) : (n == 2) ? 2 * int'((t.addr / 2) % 2) : 0;
        w  = mw.exists(key(t)) ? mw[key(t)] : 32'h0;
        for (int k = 0; k < n; k++) w[8*(st+k) +: 8] = t.wdata[8*k +: 8];
        mw[key(t)] = w;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(rvalid_m), 32'h0);
            chk("rst_req_ready", 32'(ready_m), 32'h0);
            q.delete();
        end else begin
            bit exp_v;
            chk("req_ready", 32'(ready_m), 32'(q.size() == 0));
            exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= lat(q[0]));
            chk("rsp_valid", 32'(rvalid_m), 32'(exp_v));
            if (exp_v && rvalid_m) begin
                bit e;
                cur = q[0];
                e   = m_err(cur);
                chk("rsp_error", 32'(rerr_m), 32'(e));
                chk("rsp_rdata", rdata_m, (e || cur.write) ? 32'h0 : m_load(cur));
                if (rs_ready) begin
                    if (cur.write && !e) m_store(cur);
                    void'(q.pop_front());
                end
            end
            if (ready_m && rq_valid)
                q.push_back('{sel: sel, write: rq_write, addr: rq_addr, size: rq_size,
                              wdata: rq_wdata, acc: cyc + 1});
        end
    end

    // ---------------- driver with literal expectations ----------------
    task automatic xact(input bit s, input bit w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int hold, input logic [31:0] er,
                        input bit ee, input string nm);
        int t;
        @(posedge clk); #1;
        sel = s; rq_write = w; rq_addr = a; rq_size = sz; rq_wdata = wd; rq_valid = 1'b1;
        @(negedge clk);
        t = 0;
        while (!ready_m && t < 20) begin @(negedge clk); t++; end
        if (!ready_m) begin timeout({nm, "_accept"}); rq_valid = 1'b0; return; end
        @(posedge clk); #1 rq_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!rvalid_m && t < 40) begin @(negedge clk); t++; end
        if (!rvalid_m) begin timeout({nm, "_rsp"}); return; end
        chk({nm, "_rdata"}, rdata_m, er);
        chk({nm, "_err"}, 32'(rerr_m), 32'(ee));
        repeat (hold) @(posedge clk);
        #1 rs_ready = 1'b1;
        @(posedge clk); #1 rs_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'h0);
        chk("reset_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("reset_rsp_error", 32'(bus0.rsp_error), 32'h0);
        chk("reset_req_ready", 32'(bus0.req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic word store/load
        xact(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 1, 32'h0,        0, "sw10");
        xact(0, 0, 32'h10, 3'b010, 32'h0,        1, 32'hDEADBEEF, 0, "lw10");
        // byte merge and sign/zero extension
        xact(0, 1, 32'h10, 3'b010, 32'h11223344, 1, 32'h0,        0, "sw10b");
        xact(0, 1, 32'h13, 3'b000, 32'hABCDEF80, 1, 32'h0,        0, "sb13");
        xact(0, 0, 32'h10, 3'b010, 32'h0,        3, 32'h80223344, 0, "lw10_hold");
        xact(0, 0, 32'h13, 3'b000, 32'h0,        1, 32'hFFFFFF80, 0, "lb13");
        xact(0, 0, 32'h13, 3'b100, 32'h0,        1, 32'h00000080, 0, "lbu13");
        xact(0, 0, 32'h12, 3'b001, 32'h0,        1, 32'hFFFF8022, 0, "lh12");
        xact(0, 0, 32'h12, 3'b101, 32'h0,        1, 32'h00008022, 0, "lhu12");
        xact(0, 0, 32'h10, 3'b001, 32'h0,        1, 32'h00003344, 0, "lh10");
        // halfword store, then range and size faults
        xact(0, 1, 32'h0,  3'b010, 32'h0BADF00D, 1, 32'h0,        0, "sw0");
        xact(0, 1, 32'h2,  3'b001, 32'hFFFF7E55, 1, 32'h0,        0, "sh2");
        xact(0, 0, 32'h0,  3'b010, 32'h0,        1, 32'h7E55F00D, 0, "lw0");
        xact(0, 0, 32'h1000, 3'b010, 32'h0,      1, 32'h0,        1, "lw_oor");
        xact(0, 0, 32'h10, 3'b011, 32'h0,        1, 32'h0,        1, "size011");
        xact(0, 0, 32'h10, 3'b110, 32'h0,        1, 32'h0,        1, "size110");
        xact(0, 1, 32'h1000, 3'b010, 32'hFFFFFFFF, 1, 32'h0,      1, "sw_oor");
        xact(0, 0, 32'h0,  3'b010, 32'h0,        1, 32'h7E55F00D, 0, "lw0_after_oor");
        xact(0, 1, 32'hFFC, 3'b010, 32'h12345678, 1, 32'h0,       0, "sw_last");
        xact(0, 0, 32'hFFE, 3'b101, 32'h0,       1, 32'h00001234, 0, "lhu_last");
        // misalignment behaviour depends on the build
        xact(0, 1, 32'h12, 3'b010, 32'h55667788, 1, 32'h0, MIS, "sw12");
        xact(0, 0, 32'h10, 3'b010, 32'h0, 1, MIS ? 32'h80223344 : 32'h55667788, 0, "lw10_mis");
        xact(0, 0, 32'h11, 3'b001, 32'h0, 1, MIS ? 32'h0 : 32'h00007788, MIS, "lh11");

        // reset in the middle of a wait-stated store
        xact(1, 1, 32'h20, 3'b010, 32'h11111111, 1, 32'h0,        0, "ws3_sw20");
        xact(1, 0, 32'h20, 3'b010, 32'h0,        1, 32'h11111111, 0, "ws3_lw20");
        @(posedge clk); #1;
        sel = 1'b1; rq_write = 1'b1; rq_addr = 32'h20; rq_size = 3'b010;
        rq_wdata = 32'h22222222; rq_valid = 1'b1;
        @(negedge clk);
        chk("rt_accept_ready", 32'(ready_m), 32'h1);
        @(posedge clk); #1 rq_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rt_rsp_valid", 32'(rvalid_m), 32'h0);
        chk("rt_req_ready", 32'(ready_m), 32'h0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rt_idle_ready", 32'(ready_m), 32'h1);
        chk("rt_idle_valid", 32'(rvalid_m), 32'h0);
        xact(1, 0, 32'h20, 3'b010, 32'h0, 1, 32'h11111111, 0, "rt_lw20");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
